riscv_icache_ctrl: RTL and testbench

- Direct-mapped instruction cache: tag/valid/data arrays plus the refill FSM, sitting between the fetch stage and the instruction RAM.
- Serves 32-bit instructions to fetch on a hit.
- On a miss, it stalls fetch and reads one 128-bit line from the instruction RAM through a registered, 1-cycle-latency read port. It then installs the line and replays the lookup.
- Also provides a flush for fence.i and a saturating miss counter.

---
 rtl/riscv_icache_pkg.sv | 26 ++
 rtl/riscv_icache_tag_array.sv | 33 +++
 rtl/riscv_icache_ctrl.sv | 88 ++++++++
 tb/tb_riscv_icache_ctrl.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_icache_pkg.sv
// Shared geometry, refill FSM states and word extraction for the instruction cache.
package riscv_icache_pkg;

    localparam int DATA_WIDTH  = 128;
    localparam int CACHE_SIZE  = 4 * (2 ** 10);
    localparam int MEM_SIZE    = 4 * CACHE_SIZE;
    localparam int DATAPBLOCK  = 16;
    localparam int CACHE_DEPTH = CACHE_SIZE / DATAPBLOCK;
    localparam int ADDR        = $clog2(MEM_SIZE);
    localparam int BYTE_OFF    = $clog2(DATAPBLOCK);
    localparam int INDEX       = $clog2(CACHE_DEPTH);
    localparam int TAG         = ADDR - BYTE_OFF - INDEX;
    localparam int S_ADDR      = 23;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT
    } state_t;

    function automatic logic [31:0] word_sel(input logic [DATA_WIDTH-1:0] line,
                                             input logic [1:0]            word);
        return line[{word, 5'b0} +: 32];
    endfunction

endpackage

// File: rtl/riscv_icache_tag_array.sv
// Valid bits (async reset, flush, refill set) and tag storage; hit is combinational.
// A refill write and a flush on the same edge leave only the refilled line valid.
module riscv_icache_tag_array
    import riscv_icache_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic [INDEX-1:0] idx,
    input  logic [TAG-1:0]   tag,
    input  logic             flush,
    input  logic             wr_en,
    output logic             hit
);

    logic [CACHE_DEPTH-1:0] valid;
    logic [TAG-1:0]         tag_mem [CACHE_DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= '0;
        end else begin
            if (flush) valid <= '0;
            if (wr_en) valid[idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) tag_mem[idx] <= tag;
    end

    assign hit = valid[idx] && (tag_mem[idx] == tag);

endmodule

// File: rtl/riscv_icache_ctrl.sv
// Direct-mapped I-cache: 0-cycle hit, 3-cycle miss stall (IDLE-miss, REQ, WAIT) then replay.
// Fetch must hold its address while stall is high; the address is never re-latched.
module riscv_icache_ctrl
    import riscv_icache_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  fetch_req,
    input  logic [ADDR-1:0]       fetch_addr,
    input  logic                  flush,
    output logic [31:0]           instr,
    output logic                  stall,
    output logic                  mem_rden,
    output logic [S_ADDR-1:0]     mem_addr,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic [CNT_W-1:0]      miss_cnt
);

    state_t                state, state_nxt;
    logic                  hit;
    logic                  cnt_inc;
    logic                  refill_wr;
    logic [TAG-1:0]        tag;
    logic [INDEX-1:0]      idx;
    logic [1:0]            word;
    logic [DATA_WIDTH-1:0] data_mem [CACHE_DEPTH];
    logic                  unused_addr_bits;

    assign tag              = fetch_addr[ADDR-1 -: TAG];
    assign idx              = fetch_addr[BYTE_OFF +: INDEX];
    assign word             = fetch_addr[3:2];
    assign unused_addr_bits = ^fetch_addr[1:0];
    assign refill_wr        = (state == WAIT);
    assign mem_addr         = {{(S_ADDR - ADDR + BYTE_OFF){1'b0}}, fetch_addr[ADDR-1:BYTE_OFF]};

    riscv_icache_tag_array u_tag_array (
        .clk   (clk),
        .rst_n (rst_n),
        .idx   (idx),
        .tag   (tag),
        .flush (flush),
        .wr_en (refill_wr),
        .hit   (hit)
    );

    // RAM data arrives in WAIT, one cycle after the REQ read enable.
    always_ff @(posedge clk) begin
        if (refill_wr) data_mem[idx] <= mem_rdata;
    end

    assign instr = hit ? word_sel(data_mem[idx], word) : 32'h0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            miss_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (cnt_inc) miss_cnt <= miss_cnt + 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        stall     = 1'b1;
        mem_rden  = 1'b0;
        cnt_inc   = 1'b0;
        case (state)
            IDLE: begin
                // A flush cycle stalls even on a hit so the retry sees the cleared valids.
                stall = flush || (fetch_req && !hit);
                if (fetch_req && !hit) begin
                    state_nxt = REQ;
                    cnt_inc   = ~&miss_cnt;
                end
            end
            REQ: begin
                mem_rden  = 1'b1;
                state_nxt = WAIT;
            end
            WAIT:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_riscv_icache_ctrl.sv
// Randomised and directed fetch traffic against a transaction-level cache model.
module tb_riscv_icache_ctrl;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         fetch_req;
    logic [13:0]  fetch_addr;
    logic         flush;
    logic [31:0]  instr;
    logic         stall;
    logic         mem_rden;
    logic [22:0]  mem_addr;
    logic [127:0] mem_rdata;
    logic [3:0]   miss_cnt;

    int n_chk  = 0;
    int n_fail = 0;

    logic [127:0] mem [1024];
    bit           ref_valid [256];
    logic [1:0]   ref_tag [256];
    int           ref_cnt;

    always #5 clk = ~clk;

    riscv_icache_ctrl #(.CNT_W(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .fetch_req  (fetch_req),
        .fetch_addr (fetch_addr),
        .flush      (flush),
        .instr      (instr),
        .stall      (stall),
        .mem_rden   (mem_rden),
        .mem_addr   (mem_addr),
        .mem_rdata  (mem_rdata),
        .miss_cnt   (miss_cnt)
    );

    // Registered RAM; garbage when not read so a mistimed sample shows up.
    always @(posedge clk) begin
        if (mem_rden) mem_rdata <= mem[mem_addr[9:0]];
        else          mem_rdata <= {$urandom, $urandom, $urandom, $urandom};
    end

    // Protocol: fetch holds its address across a stalled request.
    logic        stall_q = 1'b0;
    logic        req_q   = 1'b0;
    logic [13:0] addr_q  = '0;
    always @(negedge clk) begin
        if (rst_n && stall_q && req_q && fetch_req)
            assert (fetch_addr == addr_q) else $error("fetch_addr changed during stall");
        stall_q <= stall;
        req_q   <= fetch_req;
        addr_q  <= fetch_addr;
    end

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 256; i++) ref_valid[i] = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One fetch to completion; flush_phase 2/3 raises flush during REQ/WAIT of a miss.
    task automatic fetch(input logic [13:0] a, input int flush_phase);
        logic [9:0] ln;
        logic [7:0] idx;
        logic [1:0] tg;
        logic [1:0] w;
        bit         hit;
        ln  = a[13:4];
        idx = a[11:4];
        tg  = a[13:12];
        w   = a[3:2];
        hit = ref_valid[idx] && (ref_tag[idx] == tg);
        fetch_req  = 1'b1;
        fetch_addr = a;
        if (!hit) begin
            @(negedge clk);
            chk("miss_stall1", stall, 1);
            chk("miss_rden1", mem_rden, 0);
            step();
            flush = (flush_phase == 2);
            @(negedge clk);
            chk("req_stall", stall, 1);
            chk("req_rden", mem_rden, 1);
            chk("req_addr", mem_addr, {13'b0, ln});
            step();
            flush = (flush_phase == 3);
            @(negedge clk);
            chk("wait_stall", stall, 1);
            chk("wait_rden", mem_rden, 0);
            step();
            flush = 1'b0;
            if (flush_phase != 0) model_clear();
            ref_valid[idx] = 1'b1;
            ref_tag[idx]   = tg;
            if (ref_cnt != 15) ref_cnt++;
        end
        @(negedge clk);
        chk("hit_stall", stall, 0);
        chk("hit_instr", instr, mem[ln][w*32 +: 32]);
        chk("hit_rden", mem_rden, 0);
        chk("miss_cnt", miss_cnt, ref_cnt[3:0]);
        step();
    endtask

    task automatic idle_flush();
        fetch_req  = 1'b0;
        fetch_addr = 14'($urandom);
        flush      = 1'b1;
        @(negedge clk);
        chk("flush_stall", stall, 1);
        step();
        flush = 1'b0;
        model_clear();
    endtask

    task automatic idle_cycle();
        fetch_req  = 1'b0;
        fetch_addr = 14'($urandom);
        @(negedge clk);
        chk("idle_stall", stall, 0);
        chk("idle_rden", mem_rden, 0);
        step();
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = {$urandom, $urandom, $urandom, $urandom};
        mem[4][31:0] = 32'h0000_0013;
        model_clear();
        ref_cnt    = 0;
        rst_n      = 1'b0;
        fetch_req  = 1'b0;
        fetch_addr = '0;
        flush      = 1'b0;
        #12;
        chk("rst_stall", stall, 0);
        chk("rst_rden", mem_rden, 0);
        chk("rst_cnt", miss_cnt, 0);
        chk("rst_instr", instr, 0);
        rst_n = 1'b1;
        step();

        // Cold miss then same-line hits.
        fetch(14'h0040, 0);
        chk("cold_instr", mem[4][31:0], 32'h13);
        fetch(14'h0044, 0);
        fetch(14'h0048, 0);
        fetch(14'h004C, 0);
        chk("cold_cnt", miss_cnt, 1);

        // Conflict eviction on index 4.
        fetch(14'h1040, 0);
        fetch(14'h0040, 0);
        chk("conflict_cnt", miss_cnt, 3);

        // Flush during REQ: refill survives, older line is lost.
        fetch(14'h0100, 2);
        fetch(14'h0100, 0);
        fetch(14'h0040, 0);
        chk("flush_cnt", miss_cnt, 5);
        fetch(14'h0230, 3);
        fetch(14'h0234, 0);

        // Reset during WAIT.
        idle_flush();
        fetch_req  = 1'b1;
        fetch_addr = 14'h0200;
        @(negedge clk);
        chk("rr_stall", stall, 1);
        step();
        step();
        rst_n     = 1'b0;
        fetch_req = 1'b0;
        #1;
        chk("rr_stall0", stall, 0);
        chk("rr_rden0", mem_rden, 0);
        chk("rr_cnt0", miss_cnt, 0);
        chk("rr_instr0", instr, 0);
        @(negedge clk);
        rst_n = 1'b1;
        model_clear();
        ref_cnt = 0;
        step();
        fetch(14'h0200, 0);
        chk("rr_refetch_cnt", miss_cnt, 1);

        // Saturation of the 4-bit counter.
        for (int i = 0; i < 17; i++) fetch(i[0] ? 14'h1040 : 14'h0040, 0);
        chk("sat_cnt", miss_cnt, 4'hF);

        // Random traffic over a few indexes so hits, conflicts and flushes mix.
        for (int i = 0; i < 400; i++) begin
            int r;
            r = $urandom_range(0, 99);
            if (r < 8) idle_flush();
            else if (r < 16) idle_cycle();
            else begin
                logic [13:0] a;
                a = {2'($urandom_range(0, 3)), 8'($urandom_range(0, 7)), 4'($urandom)};
                fetch(a, (r < 24) ? $urandom_range(2, 3) : 0);
            end
        end

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
